// File: rtl/mem_ctrl.sv
// mem_ctrl: EX/MEM load/store unit driving an SRAM-like data bus with alignment checks and flush handling
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        flush,
  input  logic        pipe_stall,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        res_valid,
  output logic        adel,
  output logic        ades,
  output logic [31:0] badvaddr,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);
  localparam logic [7:0] LB_OP  = 8'b11100000;
  localparam logic [7:0] LBU_OP = 8'b11100100;
  localparam logic [7:0] LH_OP  = 8'b11100001;
  localparam logic [7:0] LHU_OP = 8'b11100101;
  localparam logic [7:0] LW_OP  = 8'b11100011;
  localparam logic [7:0] SB_OP  = 8'b11101000;
  localparam logic [7:0] SH_OP  = 8'b11101001;
  localparam logic [7:0] SW_OP  = 8'b11101011;
  typedef enum logic [2:0] {IDLE, REQ, DATA, DONE, DISCARD} state_t;
  state_t      state;
  logic [7:0]  op_q;
  logic [31:0] bad_q;
  logic        is_load, is_store, misaligned, take, accept, err;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_data;
  assign is_load    = op inside {LB_OP, LBU_OP, LH_OP, LHU_OP, LW_OP};
  assign is_store   = op inside {SB_OP, SH_OP, SW_OP};
  assign misaligned = (op inside {LH_OP, LHU_OP, SH_OP} && addr[0]) ||
                      (op inside {LW_OP, SW_OP} && addr[1:0] != 2'b00);
  assign take       = state == IDLE && in_valid && !flush && (is_load || is_store);
  assign accept     = take && !misaligned;
  assign err        = take && misaligned;
  assign adel       = err && is_load;
  assign ades       = err && is_store;
  // the faulting address is visible in the fault cycle itself and remembered afterwards
  assign badvaddr   = err ? addr : bad_q;
  assign stall      = accept || state == REQ || state == DATA;
  assign lane_b     = data_addr[1:0] == 2'd3 ? data_rdata[31:24] :
                      data_addr[1:0] == 2'd2 ? data_rdata[23:16] :
                      data_addr[1:0] == 2'd1 ? data_rdata[15:8]  : data_rdata[7:0];
  assign lane_h     = data_addr[1] ? data_rdata[31:16] : data_rdata[15:0];
  assign load_data  = op_q == LB_OP  ? {{24{lane_b[7]}}, lane_b} :
                      op_q == LBU_OP ? {24'h0, lane_b} :
                      op_q == LH_OP  ? {{16{lane_h[15]}}, lane_h} :
                      op_q == LHU_OP ? {16'h0, lane_h} :
                      op_q == LW_OP  ? data_rdata : 32'h0;
  // transaction FSM; a flush coinciding with the data response simply drops it, since no second response will follow
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= 8'h0;
      bad_q      <= 32'h0;
      rdata      <= 32'h0;
      res_valid  <= 1'b0;
      data_req   <= 1'b0;
      data_wr    <= 1'b0;
      data_size  <= 2'd0;
      data_addr  <= 32'h0;
      data_wdata <= 32'h0;
    end else begin
      if (err) bad_q <= addr;
      case (state)
        IDLE: if (accept) begin
          op_q       <= op;
          data_addr  <= addr;
          data_wr    <= is_store;
          data_size  <= op inside {LW_OP, SW_OP} ? 2'd2 : op inside {LH_OP, LHU_OP, SH_OP} ? 2'd1 : 2'd0;
          data_wdata <= op == SB_OP ? {4{wdata[7:0]}} : op == SH_OP ? {2{wdata[15:0]}} : wdata;
          data_req   <= 1'b1;
          state      <= REQ;
        end
        REQ: if (data_addr_ok) begin
          data_req <= 1'b0;
          state    <= flush ? DISCARD : DATA;
        end else if (flush) begin
          data_req <= 1'b0;
          state    <= IDLE;
        end
        DATA: if (data_data_ok) begin
          state <= flush ? IDLE : DONE;
          if (!flush) begin
            rdata     <= load_data;
            res_valid <= 1'b1;
          end
        end else if (flush) state <= DISCARD;
        DONE: if (flush || !pipe_stall) begin
          res_valid <= 1'b0;
          state     <= IDLE;
        end
        DISCARD: if (data_data_ok) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed and randomized checking of mem_ctrl against a transaction-level model
module tb_mem_ctrl;
  localparam logic [7:0] LB_OP  = 8'b11100000;
  localparam logic [7:0] LBU_OP = 8'b11100100;
  localparam logic [7:0] LH_OP  = 8'b11100001;
  localparam logic [7:0] LHU_OP = 8'b11100101;
  localparam logic [7:0] LW_OP  = 8'b11100011;
  localparam logic [7:0] SB_OP  = 8'b11101000;
  localparam logic [7:0] SH_OP  = 8'b11101001;
  localparam logic [7:0] SW_OP  = 8'b11101011;
  logic clk = 0, rst = 1, in_valid = 0, flush = 0, pipe_stall = 0, data_addr_ok = 0, data_data_ok = 0;
  logic [7:0]  op = 0;
  logic [31:0] addr = 0, wdata = 0, data_rdata = 0;
  logic        stall, res_valid, adel, ades, data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] rdata, badvaddr, data_addr, data_wdata;
  logic [7:0]  ops [11] = '{LB_OP, LBU_OP, LH_OP, LHU_OP, LW_OP, SB_OP, SH_OP, SW_OP, 8'h00, 8'h21, 8'hE2};
  int checks = 0, errors = 0;
  mem_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .op(op), .addr(addr), .wdata(wdata),
    .flush(flush), .pipe_stall(pipe_stall), .stall(stall), .rdata(rdata), .res_valid(res_valid),
    .adel(adel), .ades(ades), .badvaddr(badvaddr), .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic bit is_ld(input logic [7:0] o);
    return o == LB_OP || o == LBU_OP || o == LH_OP || o == LHU_OP || o == LW_OP;
  endfunction
  function automatic bit is_st(input logic [7:0] o);
    return o == SB_OP || o == SH_OP || o == SW_OP;
  endfunction
  function automatic int nbytes(input logic [7:0] o);
    if (o == LW_OP || o == SW_OP) return 4;
    if (o == LH_OP || o == LHU_OP || o == SH_OP) return 2;
    return 1;
  endfunction
  function automatic logic [31:0] fmt(input logic [7:0] o, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * (a % 4))) & 32'hFF;
    h = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    if (o == LBU_OP) return b;
    if (o == LB_OP) return b >= 128 ? b - 256 : b;
    if (o == LHU_OP) return h;
    if (o == LH_OP) return h >= 32768 ? h - 65536 : h;
    if (o == LW_OP) return rd;
    return 0;
  endfunction
  function automatic logic [31:0] bus_wd(input logic [7:0] o, input logic [31:0] wd);
    if (o == SB_OP) return (wd & 32'hFF) * 32'h01010101;
    if (o == SH_OP) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction
  // transaction-level model: a pending request, a pending response, a dropped response, or a held result
  bit en = 0, m_pa = 0, m_pd = 0, m_drop = 0, m_ready = 0;
  logic [7:0]  m_op = 0;
  logic [31:0] m_addr = 0, m_wd = 0, m_rdata = 0, m_bad = 0;
  function automatic bit m_take();
    return !(m_pa || m_pd || m_drop || m_ready) && in_valid && !flush && (is_ld(op) || is_st(op));
  endfunction
  function automatic bit m_ok();
    return addr % nbytes(op) == 0;
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      {m_pa, m_pd, m_drop, m_ready} <= 4'b0;
      m_rdata <= 0;
      m_bad   <= 0;
      en      <= 1;
    end else begin
      if (m_take() && !m_ok()) m_bad <= addr;
      if (m_take() && m_ok()) begin
        m_pa <= 1; m_op <= op; m_addr <= addr; m_wd <= wdata;
      end else if (m_pa) begin
        if (data_addr_ok || flush) m_pa <= 0;
        if (data_addr_ok && flush) m_drop <= 1;
        if (data_addr_ok && !flush) m_pd <= 1;
      end else if (m_pd) begin
        if (data_data_ok || flush) m_pd <= 0;
        if (data_data_ok && !flush) begin
          m_ready <= 1;
          m_rdata <= fmt(m_op, m_addr, data_rdata);
        end else if (!data_data_ok && flush) m_drop <= 1;
      end else if (m_drop) begin
        if (data_data_ok) m_drop <= 0;
      end else if (m_ready && (flush || !pipe_stall)) m_ready <= 0;
    end
  end
  // compare every cycle, mid-period, once the model has seen a reset
  always @(negedge clk) if (en) begin
    chk("stall", stall, (m_take() && m_ok()) || m_pa || m_pd);
    chk("adel", adel, m_take() && !m_ok() && is_ld(op));
    chk("ades", ades, m_take() && !m_ok() && is_st(op));
    chk("badvaddr", badvaddr, m_take() && !m_ok() ? addr : m_bad);
    chk("data_req", data_req, m_pa);
    chk("res_valid", res_valid, m_ready);
    chk("rdata", rdata, m_rdata);
    if (m_pa) begin
      chk("data_wr", data_wr, is_st(m_op));
      chk("data_size", data_size, nbytes(m_op) / 2);
      chk("data_addr", data_addr, m_addr);
      chk("data_wdata", data_wdata, bus_wd(m_op, m_wd));
    end
  end
  task automatic next();
    @(posedge clk);
    #1;
  endtask
  task automatic txn(input string n, input logic [7:0] o, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] rd, input logic [1:0] sz, input logic [31:0] ewd, input logic [31:0] er);
    int hi = 0;
    in_valid = 1; op = o; addr = a; wdata = wd;
    @(negedge clk); hi += int'(stall); next();
    in_valid = 0; op = 0; data_addr_ok = 1;
    @(negedge clk); hi += int'(stall);
    chk({n, " req"}, data_req, 1);
    chk({n, " addr"}, data_addr, a);
    chk({n, " wr"}, data_wr, is_st(o));
    chk({n, " size"}, data_size, sz);
    if (is_st(o)) chk({n, " wdata"}, data_wdata, ewd);
    next();
    data_addr_ok = 0; data_data_ok = 1; data_rdata = rd;
    @(negedge clk); hi += int'(stall); next();
    data_data_ok = 0;
    @(negedge clk); hi += int'(stall);
    chk({n, " res_valid"}, res_valid, 1);
    chk({n, " rdata"}, rdata, er);
    chk({n, " stall cycles"}, hi, 3);
    next();
  endtask
  initial begin
    next(); next();
    rst = 0;
    @(negedge clk);
    chk("rst data_req", data_req, 0);
    chk("rst stall", stall, 0);
    chk("rst res_valid", res_valid, 0);
    chk("rst rdata", rdata, 0);
    chk("rst bus", {data_wr, data_size} | data_addr | data_wdata | badvaddr, 0);
    next();
    txn("LW", LW_OP, 32'h80001000, 0, 32'hDEADBEEF, 2, 0, 32'hDEADBEEF);
    txn("LB", LB_OP, 32'h80001003, 0, 32'h80FF0102, 0, 0, 32'hFFFFFF80);
    txn("LBU", LBU_OP, 32'h80001003, 0, 32'h80FF0102, 0, 0, 32'h00000080);
    txn("LHU", LHU_OP, 32'h80001002, 0, 32'h80FF0102, 1, 0, 32'h000080FF);
    in_valid = 1; op = LW_OP; addr = 32'h80003000; next();
    in_valid = 0; data_addr_ok = 1; next();
    data_addr_ok = 0; flush = 1;
    @(negedge clk); chk("flush data stall", stall, 1); next();
    flush = 0;
    @(negedge clk); chk("discard stall", stall, 0); chk("discard res_valid", res_valid, 0); next();
    data_data_ok = 1; data_rdata = 32'h11111111;
    @(negedge clk); chk("discard res_valid 2", res_valid, 0); next();
    data_data_ok = 0; in_valid = 1; op = LW_OP; addr = 32'h80003004;
    @(negedge clk);
    chk("discard rdata kept", rdata, 32'h000080FF);
    chk("after discard accept", stall, 1);
    next();
    in_valid = 0; data_addr_ok = 1; next();
    data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'hCAFEF00D; pipe_stall = 1; next();
    data_data_ok = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold res_valid", res_valid, 1);
      chk("hold rdata", rdata, 32'hCAFEF00D);
      next();
    end
    pipe_stall = 0; next();
    @(negedge clk); chk("hold release", res_valid, 0);
    txn("SH", SH_OP, 32'h80002002, 32'h1234ABCD, 32'h55555555, 1, 32'hABCDABCD, 0);
    in_valid = 1; op = LW_OP; addr = 32'h80000002;
    @(negedge clk);
    chk("LW mis adel", adel, 1);
    chk("LW mis badvaddr", badvaddr, 32'h80000002);
    chk("LW mis stall", stall, 0);
    next();
    op = SW_OP; addr = 32'h80000001;
    @(negedge clk);
    chk("SW mis ades", ades, 1);
    chk("SW mis adel", adel, 0);
    chk("mis data_req", data_req, 0);
    next();
    op = LW_OP; addr = 32'h80004000; next();
    in_valid = 0; rst = 1;
    @(negedge clk); chk("req before rst", data_req, 1); next();
    rst = 0; in_valid = 1; op = LB_OP; addr = 32'h80004001;
    @(negedge clk);
    chk("rst mid data_req", data_req, 0);
    chk("rst mid res_valid", res_valid, 0);
    chk("rst mid idle accept", stall, 1);
    next();
    in_valid = 0;
    for (int i = 0; i < 4000; i++) begin
      rst = $urandom_range(99) == 0;
      in_valid = $urandom_range(3) != 0;
      op = ops[$urandom_range(10)];
      addr = $urandom; wdata = $urandom; data_rdata = $urandom;
      data_addr_ok = $urandom_range(1) == 1;
      data_data_ok = $urandom_range(2) == 0;
      flush = $urandom_range(9) == 0;
      pipe_stall = $urandom_range(2) == 0;
      next();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 The block SHALL have no parameters; widths are fixed at 32-bit address and data.
REQ-002 The port list SHALL be as follows; the clock is clk, the reset is rst, there is one clock, and rst SHALL be synchronous and active-high:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  EX/MEM slot holds a valid instruction
op  in  8  EXE_*_OP code from defines.vh; memory ops: LB, LBU, LH, LHU, LW, SB, SH, SW
addr  in  32  effective address (ALU y)
wdata  in  32  store data (rt value)
flush  in  1  squash the current instruction
pipe_stall  in  1  a later stage is stalling the pipeline
stall  out  1  hold the pipeline for this access
rdata  out  32  formatted load result
res_valid  out  1  rdata is valid this cycle
adel  out  1  load address error
ades  out  1  store address error
badvaddr  out  32  faulting address
data_req  out  1  SRAM-like request
data_wr  out  1  1 = store
data_size  out  2  0 = byte, 1 = half, 2 = word
data_addr  out  32  request address
data_wdata  out  32  store data on bus
data_addr_ok  in  1  request accepted
data_data_ok  in  1  response done
data_rdata  in  32  read data

Function
REQ-003 The FSM SHALL have the states IDLE, REQ, DATA, DONE and DISCARD.
REQ-004 The alignment check SHALL be combinational on addr: LH, LHU and SH need addr[0]=0; LW and SW need addr[1:0]=0; byte ops are always aligned.
REQ-005 A misaligned memory op with in_valid=1, flush=0 and state IDLE SHALL:
- assert adel (loads) or ades (stores) in the same cycle, with badvaddr=addr;
- issue no bus request;
- leave stall=0.
REQ-006 An aligned memory op with in_valid=1, flush=0 and state IDLE SHALL be accepted in that cycle: op, addr and wdata are registered, stall=1, and the next state is REQ.
REQ-007 In REQ, data_req SHALL be 1 and data_wr, data_size, data_addr and data_wdata SHALL be driven from the registered values.
- data_addr is the full registered addr.
- data_wdata is {4{wdata[7:0]}} for SB, {2{wdata[15:0]}} for SH, and wdata for SW.
REQ-008 In REQ, data_addr_ok=1 SHALL move the FSM to DATA and deassert data_req from the next cycle; otherwise the FSM stays in REQ with the request held stable.
REQ-009 In DATA, the block SHALL wait for data_data_ok; on data_data_ok it SHALL register the formatted rdata and move to DONE.
REQ-010 Load formatting SHALL be little-endian:
- LB/LBU select byte lane addr[1:0]; LB sign-extends, LBU zero-extends.
- LH/LHU select half lane addr[1]; LH sign-extends, LHU zero-extends.
- LW passes data_rdata unchanged.
- Stores SHALL give rdata=0.
REQ-011 stall SHALL be 1 in the accept cycle and throughout REQ and DATA, and SHALL be 0 in DONE and DISCARD.
REQ-012 In DONE, res_valid SHALL be 1 and rdata held; with pipe_stall=1 the FSM stays in DONE, with pipe_stall=0 it goes to IDLE, and no new op is accepted in DONE.
REQ-013 Total latency SHALL be 1 accept cycle, plus the addr_ok wait, plus the data_ok wait, plus 1 DONE cycle; with zero-wait addr_ok and next-cycle data_ok, stall is high for exactly 3 cycles.
REQ-014 Flush rules:
- flush in IDLE blocks acceptance and the address-error outputs;
- flush in REQ without addr_ok returns to IDLE and data_req drops the next cycle;
- flush in REQ together with addr_ok goes to DISCARD;
- flush in DATA goes to DISCARD;
- flush in DONE goes to IDLE.
REQ-015 DISCARD SHALL wait for data_data_ok, drop the response (res_valid stays 0, rdata unchanged) and then go to IDLE; a flush arriving in DISCARD has no further effect.
REQ-016 A non-memory op SHALL produce no request and stall=0, and adel, ades and res_valid SHALL stay 0.
REQ-017 data_addr_ok and data_data_ok SHALL be ignored in states where they are not awaited.

Reset
REQ-018 When rst=1 at a clock edge, the state SHALL be IDLE and all registered outputs SHALL be 0: rdata, res_valid, data_req, data_wr, data_size, data_addr, data_wdata, badvaddr.
REQ-019 Reset in any state, including mid-transaction, SHALL abandon the transaction with no response delivered.

Verification
REQ-020 LW with addr=0x80001000, addr_ok in the cycle after accept, data_ok one cycle later with data_rdata=0xDEADBEEF -> stall high 3 cycles, then res_valid=1 and rdata=0xDEADBEEF.
REQ-021 LB with addr=0x80001003 and data_rdata=0x80FF0102 -> rdata=0xFFFFFF80; LBU with the same stimulus -> rdata=0x00000080; LHU with addr=...02 -> rdata=0x000080FF.
REQ-022 SH with addr=0x80002002 and wdata=0x1234ABCD -> data_wr=1, data_size=1, data_wdata=0xABCDABCD, rdata=0.
REQ-023 LW with addr=0x80000002 -> adel=1, badvaddr=0x80000002, data_req never asserted, stall=0; SW with addr=...01 -> ades=1.
REQ-024 Flush in DATA, then data_ok 2 cycles later -> res_valid stays 0 and the state returns to IDLE; pipe_stall held 3 cycles in DONE -> res_valid and rdata stable for 3 cycles.
REQ-025 rst asserted in REQ -> the next cycle data_req=0, stall=0, and state IDLE.
